// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_unit
// Description : Fetch stage with PC, one-read-per-cycle IMEM interface and a
//               small circular instruction queue; handles redirects and
//               misaligned-target faults.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_unit #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              QDEPTH   = 4
) (
   input  logic            clk,
   input  logic            cpu_rst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_rd_en,
   output logic [XLEN-1:0] imem_rd_addr,
   input  logic [XLEN-1:0] imem_rd_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_instr,
   output logic [XLEN-1:0] out_pc,
   output logic            out_fault
);

   localparam int            c_pw    = $clog2(QDEPTH);
   localparam int            c_cw    = c_pw + 1;
   localparam logic [c_cw:0] c_depth = (c_cw+1)'(QDEPTH);

   typedef enum logic [0:0] {
      S_FETCH = 1'b0,
      S_HALT  = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [XLEN-1:0]   r_pc;
   logic              r_inflight;
   logic [XLEN-1:0]   r_inflight_pc;

   logic [XLEN-1:0]   r_q_instr [QDEPTH];
   logic [XLEN-1:0]   r_q_pc    [QDEPTH];
   logic [QDEPTH-1:0] r_q_fault;
   logic [c_pw-1:0]   r_rd_ptr;
   logic [c_pw-1:0]   r_wr_ptr;
   logic [c_cw-1:0]   r_count;

   logic              w_credit;
   logic              w_misaligned;
   logic              w_issue;
   logic              w_fault_push;
   logic              w_resp;
   logic              w_push;
   logic              w_pop;
   logic [XLEN-1:0]   w_push_instr;
   logic [XLEN-1:0]   w_push_pc;

   // Credits count the in-flight read so its response always has a free slot.
   assign w_credit     = ({1'b0, r_count} + {{c_cw{1'b0}}, r_inflight}) < c_depth;
   assign w_misaligned = (r_pc[1:0] != 2'b00);
   assign w_resp       = r_inflight & ~redirect_valid;
   assign out_valid    = (r_count != '0);
   assign w_pop        = out_valid & out_ready;
   assign w_push       = w_resp | w_fault_push;
   assign w_push_instr = w_fault_push ? '0 : imem_rd_data;
   assign w_push_pc    = w_fault_push ? r_pc : r_inflight_pc;

   assign imem_rd_en   = w_issue & ~cpu_rst;
   assign imem_rd_addr = r_pc;
   assign out_instr    = r_q_instr[r_rd_ptr];
   assign out_pc       = r_q_pc[r_rd_ptr];
   assign out_fault    = r_q_fault[r_rd_ptr];

   always_comb begin
      w_state_nxt  = r_state;
      w_issue      = 1'b0;
      w_fault_push = 1'b0;
      case (r_state)
         S_FETCH: begin
            if (!redirect_valid && w_credit) begin
               if (w_misaligned) begin
                  // A misaligned target only ever follows a redirect, so no read is in flight.
                  if (!r_inflight) begin
                     w_fault_push = 1'b1;
                     w_state_nxt  = S_HALT;
                  end
               end else begin
                  w_issue = 1'b1;
               end
            end
         end
         S_HALT:  ;
         default: w_state_nxt = S_FETCH;
      endcase
      if (redirect_valid)
         w_state_nxt = S_FETCH;
   end

   always_ff @(posedge clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         r_state       <= S_FETCH;
         r_pc          <= RESET_PC;
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_inflight <= w_issue;
         if (w_issue)
            r_inflight_pc <= r_pc;
         if (redirect_valid)
            r_pc <= redirect_pc;
         else if (w_issue)
            r_pc <= r_pc + XLEN'(4);
      end
   end

   always_ff @(posedge clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         for (int i = 0; i < QDEPTH; i++) begin
            r_q_instr[i] <= '0;
            r_q_pc[i]    <= '0;
         end
         r_q_fault <= '0;
         r_rd_ptr  <= '0;
         r_wr_ptr  <= '0;
         r_count   <= '0;
      end else if (redirect_valid) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_q_instr[r_wr_ptr] <= w_push_instr;
            r_q_pc[r_wr_ptr]    <= w_push_pc;
            r_q_fault[r_wr_ptr] <= w_fault_push;
            r_wr_ptr            <= r_wr_ptr + c_pw'(1);
         end
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + c_pw'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_cw'(1);
            2'b01:   r_count <= r_count - c_cw'(1);
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage that owns the program counter, issues one read per cycle to the synchronous instruction memory (1-cycle read latency), and buffers the returned words in a small FIFO. It sits between the instruction memory interface and the decode stage. It supports pipeline redirects, such as branches and jumps, with flush and kill of in-flight reads. It flags misaligned fetch targets instead of fetching them.

## Interface
Parameters:
- XLEN, 32, datapath and address width
- RESET_PC, 32'h0000_0000, PC loaded on reset
- QDEPTH, 4, instruction queue entries (power of two, ≥2)

Ports:
- clk  input  1  core clock, all state on rising edge
- cpu_rst  input  1  asynchronous, active-high reset
- redirect_valid  input  1  redirect request from execute
- redirect_pc  input  XLEN  redirect target (byte address)
- imem_rd_en  output  1  read request this cycle
- imem_rd_addr  output  XLEN  byte address of request (= fetch PC)
- imem_rd_data  input  XLEN  read data, valid the cycle after imem_rd_en
- out_valid  output  1  queue head valid
- out_ready  input  1  decode accepts head
- out_instr  output  XLEN  head instruction word
- out_pc  output  XLEN  PC of head instruction
- out_fault  output  1  head is a misaligned-fetch fault marker (out_instr = 0)

## Operation
- State machine: FETCH, HALT.
  - FETCH: issue reads while credits are available.
  - HALT: no reads. Entered when a misaligned PC is latched. Left only on redirect or reset.
- Credits: issue when (queue count + in-flight) < QDEPTH. In-flight is at most 1.
- Issue in FETCH:
  - imem_rd_en = 1, imem_rd_addr = pc.
  - pc <= pc + 4 (mod 2^XLEN, wrap-around silent).
  - Record in-flight with its PC.
- Response: the cycle after an issue, if not killed, push {imem_rd_data, inflight_pc, fault=0} into the queue.
- Misalignment: pc[1:0] != 0, checked only on bits [1:0].
  - Instead of issuing, push {0, pc, fault=1} when a queue slot is free.
  - Then enter HALT.
- Redirect (redirect_valid = 1):
  - Flush the queue (count <= 0).
  - Kill any in-flight response arriving next cycle.
  - pc <= redirect_pc, state <= FETCH.
  - No read is issued in the redirect cycle (imem_rd_en = 0).
- Redirect coincides with an out handshake: the head counts as consumed, and the flush still applies.
- Redirect coincides with a response arrival: the response is dropped.
- Simultaneous push and pop on a full queue: allowed only when the credit rule admitted the issue, so there is never an overflow.
- Pop on out_valid & out_ready: the head advances.
- Queue is a circular buffer with wrapping read/write pointers and a count of 0..QDEPTH.
- Outputs out_instr, out_pc, out_fault come from the queue head (registered storage). They are don't-care when out_valid = 0.

## Timing
- Reset values:
  - pc = RESET_PC, state = FETCH, queue empty, no in-flight.
  - out_valid = 0, imem_rd_en = 0, imem_rd_addr = RESET_PC.
  - out_pc = 0, out_instr = 0, out_fault = 0.
- First edge after reset release: imem_rd_en = 1 with address RESET_PC in cycle 0.
- Latency, request to out_valid:
  - Request in cycle N.
  - Data present in cycle N+1, written at the end of N+1.
  - out_valid in cycle N+2.
- Throughput: 1 instruction/cycle sustained with out_ready held high.
- Redirect to first new instruction:
  - Redirect in cycle R.
  - Request to redirect_pc in R+1.
  - out_valid in R+3.
- Backpressure: with out_ready low, exactly QDEPTH words are buffered, and imem_rd_en then stays 0.
- Reset asserted mid-operation: all state clears immediately (asynchronous). In-flight data is discarded.

## Test plan
- Reset release, memory words 0x00000013, 0x00100093, 0x00200113 at 0x0, 0x4, 0x8, out_ready = 1 -> out_valid first high in cycle 2; out_pc = 0x0, 0x4, 0x8 on consecutive cycles with matching words.
- out_ready = 0 from reset -> 4 entries buffered, imem_rd_en low thereafter, out_pc stays 0x0. Then raise out_ready -> 0x0, 0x4, 0x8, 0xC pop back-to-back with no gap before 0x10.
- Redirect to 0x100 while queue holds 3 entries and a read is in flight -> out_valid drops next cycle, stale word never appears; next out_pc = 0x100 three cycles after the redirect.
- Redirect to 0x102 -> single entry with out_fault = 1, out_pc = 0x102, out_instr = 0; imem_rd_en stays 0 until a redirect to 0x200 resumes fetch.
- pc = 0xFFFFFFFC -> next request address 0x00000000 (wrap), and the fetch stream continues.
- cpu_rst pulsed mid-stream with a read in flight -> outputs return to reset values immediately; after release the fetch restarts at RESET_PC with no stale entry.
